// File: rtl/sm_polar_encoder_pkg.sv
// Shared definitions for the SM polar encoder: FSM state encoding and default code parameters.
// The defaults describe the (8,4) test code with info bits at u3, u5, u6, u7.
package sm_polar_encoder_pkg;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_ENCODE = 2'd1,
        ST_OUTPUT = 2'd2
    } state_t;

    localparam int         DEF_N           = 8;
    localparam int         DEF_LOG2N       = 3;
    localparam logic [7:0] DEF_FROZEN_MASK = 8'b00010111;
    localparam int         DEF_Q           = 8;
    localparam int         DEF_AMP         = 31;

endpackage

// File: rtl/sm_polar_encoder_butterfly_stage.sv
// One polar-transform stage: u[i] ^= u[i + 2^stage] for every i with bit 'stage' clear.
// Purely combinational; the caller registers the result once per stage.
module sm_polar_encoder_butterfly_stage #(
    parameter int N     = 8,
    parameter int LOG2N = 3
) (
    input  logic [N-1:0]     din,
    input  logic [LOG2N-1:0] stage,
    output logic [N-1:0]     dout
);

    always_comb begin
        dout = din;
        for (int s = 0; s < LOG2N; s++) begin
            if (stage == LOG2N'(s)) begin
                for (int i = 0; i < N; i++) begin
                    // i | 2^s equals i + 2^s exactly when bit s of i is clear, and stays in range.
                    if (((i >> s) & 1) == 0) begin
                        dout[i] = din[i] ^ din[i | (1 << s)];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/sm_polar_encoder.sv
// Frame-based polar encoder: loads K info bits (zeros at frozen slots), runs LOG2N butterfly
// stages, then streams x[0..N-1] as hard bit plus sign-magnitude symbol; valid/ready on both sides.
module sm_polar_encoder
    import sm_polar_encoder_pkg::*;
#(
    parameter int             N           = DEF_N,
    parameter int             LOG2N       = DEF_LOG2N,
    parameter logic [N-1:0]   FROZEN_MASK = N'(DEF_FROZEN_MASK),
    parameter int             Q           = DEF_Q,
    parameter logic [Q-2:0]   AMP         = (Q-1)'(DEF_AMP)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_bit,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         out_bit,
    output logic         out_sign,
    output logic [Q-2:0] out_val,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic         busy
);

    localparam logic [LOG2N-1:0] IDX_LAST   = LOG2N'(N - 1);
    localparam logic [LOG2N-1:0] STAGE_LAST = LOG2N'(LOG2N - 1);

    state_t           state;
    state_t           state_nxt;
    logic [LOG2N-1:0] idx;
    logic [LOG2N-1:0] stage;
    logic [N-1:0]     u;
    logic [N-1:0]     u_bfly;

    logic slot_frozen;
    logic idx_last;
    logic stage_last;
    logic load_adv;

    assign slot_frozen = FROZEN_MASK[idx];
    assign idx_last    = (idx == IDX_LAST);
    assign stage_last  = (stage == STAGE_LAST);
    // Frozen slots advance on their own; info slots wait for upstream data.
    assign load_adv    = (state == ST_LOAD) && (slot_frozen || in_valid);

    sm_polar_encoder_butterfly_stage #(
        .N     (N),
        .LOG2N (LOG2N)
    ) u_stage (
        .din   (u),
        .stage (stage),
        .dout  (u_bfly)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_LOAD: begin
                if (load_adv && idx_last) begin
                    state_nxt = ST_ENCODE;
                end
            end
            ST_ENCODE: begin
                if (stage_last) begin
                    state_nxt = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                if (out_ready && idx_last) begin
                    state_nxt = ST_LOAD;
                end
            end
            default: state_nxt = ST_LOAD;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_bit   = 1'b0;
        out_sign  = 1'b0;
        out_val   = '0;
        out_last  = 1'b0;
        busy      = 1'b0;
        case (state)
            ST_LOAD: begin
                in_ready = !slot_frozen;
            end
            ST_ENCODE: begin
                busy = 1'b1;
            end
            ST_OUTPUT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_bit   = u[idx];
                out_sign  = u[idx];
                out_val   = AMP;
                out_last  = idx_last;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx   <= '0;
            stage <= '0;
            u     <= '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    stage <= '0;
                    if (load_adv) begin
                        u[idx] <= !slot_frozen && in_bit;
                        idx    <= idx_last ? '0 : idx + 1'b1;
                    end
                end
                ST_ENCODE: begin
                    u     <= u_bfly;
                    stage <= stage + 1'b1;
                    idx   <= '0;
                end
                ST_OUTPUT: begin
                    if (out_ready) begin
                        idx <= idx_last ? '0 : idx + 1'b1;
                    end
                end
                default: begin
                    idx   <= '0;
                    stage <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sm_polar_encoder.sv
// Bench for sm_polar_encoder (N=8, mask 00010111, AMP=31): directed frames plus a subset-XOR
// reference model checked symbol by symbol, with random back-pressure and mid-frame resets.
module tb_sm_polar_encoder;

    localparam logic [7:0] MASK = 8'b00010111;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_bit = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       out_bit;
    logic       out_sign;
    logic [6:0] out_val;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       out_last;
    logic       busy;

    sm_polar_encoder #(
        .N           (8),
        .LOG2N       (3),
        .FROZEN_MASK (MASK),
        .Q           (8),
        .AMP         (7'd31)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_bit    (in_bit),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_bit   (out_bit),
        .out_sign  (out_sign),
        .out_val   (out_val),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int por = 100;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        out_ready = ($urandom_range(0, 99) < por);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Info bit k (k-th accepted) lands on the k-th non-frozen position, ascending.
    function automatic logic [7:0] place(input logic [3:0] info);
        logic [7:0] u;
        int k;
        u = '0;
        k = 0;
        for (int i = 0; i < 8; i++) begin
            if (!MASK[i]) begin
                u[i] = info[k];
                k++;
            end
        end
        return u;
    endfunction

    // x[j] is the parity of u over every index that contains all bits of j.
    function automatic logic [7:0] polar_ref(input logic [7:0] u);
        logic [7:0] x;
        for (int j = 0; j < 8; j++) begin
            x[j] = 1'b0;
            for (int i = 0; i < 8; i++) begin
                if ((i & j) == j) x[j] = x[j] ^ u[i];
            end
        end
        return x;
    endfunction

    bit         info_acc[$];
    bit         exp_bits[$];
    logic [7:0] got_frames[$];
    logic [7:0] got_cur = '0;
    int         pos = 0;
    logic       prev_stall = 1'b0;
    logic [10:0] prev_vec = '0;
    int         last_in_cyc = 0;
    int         lat = -1;
    int         olast_cyc = -1;
    int         gap = -1;
    logic       wait_first = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            info_acc.delete();
            exp_bits.delete();
            pos = 0;
            prev_stall = 1'b0;
            wait_first = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                if (info_acc.size() == 0 && olast_cyc >= 0) gap = cyc - olast_cyc;
                info_acc.push_back(in_bit);
                if (info_acc.size() == 4) begin
                    logic [3:0] inf;
                    logic [7:0] x;
                    for (int k = 0; k < 4; k++) inf[k] = info_acc[k];
                    x = polar_ref(place(inf));
                    for (int j = 0; j < 8; j++) exp_bits.push_back(x[j]);
                    info_acc.delete();
                    last_in_cyc = cyc;
                    wait_first = 1'b1;
                end
            end
            if (prev_stall) begin
                chk("stall_hold", {out_valid, out_bit, out_sign, out_last, out_val}, prev_vec);
            end
            if (out_valid) begin
                chk("in_ready_in_output", in_ready, 1'b0);
                if (wait_first) begin
                    lat = cyc - last_in_cyc;
                    wait_first = 1'b0;
                end
                if (exp_bits.size() == 0) begin
                    chk("unexpected_symbol", out_valid, 1'b0);
                end else begin
                    chk("out_bit", out_bit, exp_bits[0]);
                    chk("out_sign", out_sign, exp_bits[0]);
                    chk("out_val", out_val, 31);
                    chk("out_last", out_last, (pos == 7));
                    if (out_ready) begin
                        got_cur[pos] = out_bit;
                        void'(exp_bits.pop_front());
                        if (pos == 7) begin
                            got_frames.push_back(got_cur);
                            pos = 0;
                            olast_cyc = cyc;
                        end else begin
                            pos++;
                        end
                    end
                end
                prev_stall = !out_ready;
                prev_vec = {out_valid, out_bit, out_sign, out_last, out_val};
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    task automatic send_bit(input logic b, input int pv);
        logic hs;
        int guard;
        guard = 0;
        in_bit = b;
        do begin
            in_valid = ($urandom_range(0, 99) < pv);
            @(negedge clk);
            hs = in_valid && in_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!hs && guard < 500);
        if (!hs) chk("send_timeout", hs, 1'b1);
    endtask

    task automatic send_frame(input logic [3:0] info, input int pv);
        for (int k = 0; k < 4; k++) send_bit(info[k], pv);
    endtask

    task automatic wait_frames(input int n);
        int g;
        g = 0;
        while (got_frames.size() < n && g < 3000) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (got_frames.size() < n) chk("frame_timeout", got_frames.size(), n);
    endtask

    task automatic check_frame(input string name, input logic [7:0] exp);
        wait_frames(1);
        if (got_frames.size() > 0) chk(name, got_frames.pop_front(), exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1'b0);
        chk({tag, "_out_valid"}, out_valid, 1'b0);
        chk({tag, "_out_last"}, out_last, 1'b0);
        chk({tag, "_out_bit"}, out_bit, 1'b0);
        chk({tag, "_out_sign"}, out_sign, 1'b0);
        chk({tag, "_out_val"}, out_val, 0);
        chk({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        int g;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        chk("model_case1", polar_ref(place(4'b0001)), 8'h0F);
        chk("model_last_only", polar_ref(place(4'b1000)), 8'hFF);
        chk("model_all_ones", polar_ref(place(4'b1111)), 8'h96);

        por = 100;
        send_frame(4'b0001, 100);
        in_valid = 1'b0;
        check_frame("case1_frame", 8'h0F);

        send_frame(4'b1000, 100);
        in_valid = 1'b0;
        check_frame("last_only_frame", 8'hFF);

        send_frame(4'b0000, 100);
        in_valid = 1'b0;
        check_frame("zero_frame", 8'h00);

        lat = -1;
        send_frame(4'b1111, 100);
        in_valid = 1'b0;
        check_frame("all_ones_frame", 8'h96);
        chk("latency", lat, 4);

        // Back-to-back frames with in_valid never dropped.
        send_frame(4'b0101, 100);
        gap = -1;
        send_frame(4'b0011, 100);
        chk("restart_gap", gap, 4);
        wait_frames(2);
        if (got_frames.size() >= 2) begin
            chk("b2b_frame0", got_frames.pop_front(), polar_ref(place(4'b0101)));
            chk("b2b_frame1", got_frames.pop_front(), polar_ref(place(4'b0011)));
        end
        in_valid = 1'b0;

        got_frames.delete();
        por = 60;
        for (int f = 0; f < 100; f++) begin
            send_frame(4'($urandom_range(0, 15)), 60);
        end
        in_valid = 1'b0;
        wait_frames(100);
        chk("random_frames", got_frames.size(), 100);
        got_frames.delete();

        // Reset mid-LOAD.
        por = 100;
        send_bit(1'b1, 100);
        send_bit(1'b1, 100);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_load");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset mid-OUTPUT while stalled.
        por = 0;
        send_frame(4'b1111, 100);
        in_valid = 1'b0;
        g = 0;
        while (!out_valid && g < 200) begin
            @(posedge clk);
            #1;
            g++;
        end
        chk("reach_output", out_valid, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_output");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        por = 100;

        send_frame(4'b0001, 100);
        in_valid = 1'b0;
        check_frame("post_reset_frame", 8'h0F);
        repeat (20) @(posedge clk);
        #1;
        chk("no_stale_frames", got_frames.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
